// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the bit-select multiplexer.
//   MUX_WIDTH_DEF     default number of data inputs
//   MUX_CHANNELS_DEF  default select bus width
//   min_sel_width()   smallest select width able to address a given width
// ----------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_WIDTH_DEF    = 16;
    localparam int MUX_CHANNELS_DEF = 4;

    // A single select bit is still needed for the smallest legal width of 2.
    function automatic int min_sel_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// ----------------------------------------------------------------------------
// mux2_cell
// One 2:1 node of the selection tree.
//   a  input  1  chosen when s = 0
//   b  input  1  chosen when s = 1
//   s  input  1  node select
//   y  output 1  selected bit
// ----------------------------------------------------------------------------
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux.sv
// ----------------------------------------------------------------------------
// mux
// Routes one bit of a data bus to a single output, with an out-of-range flag
// and registered copies of both.
//   clk        input   1         rising-edge clock for the registered outputs
//   rst_n      input   1         asynchronous active-low reset
//   data       input   width     data bits, bit i is channel i
//   select     input   channels  index of the bit to route (unsigned)
//   result     output  1         combinational selected bit, 0 when out of range
//   sel_err    output  1         combinational flag, high when select >= width
//   result_q   output  1         registered result
//   sel_err_q  output  1         registered sel_err
// ----------------------------------------------------------------------------
module mux
    import mux_pkg::*;
#(
    parameter int width    = MUX_WIDTH_DEF,
    parameter int channels = MUX_CHANNELS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [width-1:0]    data,
    input  logic [channels-1:0] select,
    output logic                result,
    output logic                sel_err,
    output logic                result_q,
    output logic                sel_err_q
);

    localparam int LEAVES = 1 << channels;

    // Width as a channels+1 bit constant so the range compare is unsigned and
    // can represent width == 2**channels without truncation.
    localparam logic [channels:0] WIDTH_V = (channels + 1)'(width);

    generate
        if (width < 2 || width > 1024) begin : g_bad_width
            $error("mux: width=%0d outside legal range 2..1024", width);
        end
        if (channels < min_sel_width(width)) begin : g_bad_channels
            $error("mux: channels=%0d too narrow to address width=%0d", channels, width);
        end
    endgenerate

    // Heap-ordered tree: node k has children 2k+1 (select bit 0) and 2k+2
    // (select bit 1); leaves occupy the top LEAVES entries in channel order.
    logic [2*LEAVES-2:0] node;
    logic [LEAVES-1:0]   padded;

    // Channels beyond width are tied to zero so an out-of-range select
    // already drives a 0 out of the tree.
    always_comb begin
        padded              = '0;
        padded[width-1:0]   = data;
    end

    assign node[2*LEAVES-2:LEAVES-1] = padded;

    // The root level resolves the MSB of select, the leaf level the LSB.
    generate
        for (genvar d = 0; d < channels; d++) begin : g_level
            for (genvar j = 0; j < (1 << d); j++) begin : g_node
                localparam int K = (1 << d) - 1 + j;
                mux2_cell u_cell (
                    .a (node[2*K+1]),
                    .b (node[2*K+2]),
                    .s (select[channels-1-d]),
                    .y (node[K])
                );
            end
        end
    endgenerate

    assign sel_err = ({1'b0, select} >= WIDTH_V);
    assign result  = sel_err ? 1'b0 : node[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            result_q  <= result;
            sel_err_q <= sel_err;
        end
    end

endmodule

// File: tb/tb_mux.sv
// ----------------------------------------------------------------------------
// tb_mux
// Self-checking bench for mux: a default 16-bit instance and a 12-bit
// instance for out-of-range selects. Table-driven vectors with a scoreboard
// queue for the registered outputs, plus hand-written reset/data sequences.
// ----------------------------------------------------------------------------
module tb_mux;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  sel;
        logic        exp_result;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  select;
    logic        result, sel_err, result_q, sel_err_q;

    logic [11:0] data12;
    logic [3:0]  select12;
    logic        result12, sel_err12, result12_q, sel_err12_q;

    int assert_count = 0;
    int fail_count   = 0;

    vec_t vecs16 [23];
    vec_t vecs12 [6];
    vec_t exp_q16 [$];
    vec_t exp_q12 [$];

    mux u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .select    (select),
        .result    (result),
        .sel_err   (sel_err),
        .result_q  (result_q),
        .sel_err_q (sel_err_q)
    );

    mux #(.width(12), .channels(4)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data12),
        .select    (select12),
        .result    (result12),
        .sel_err   (sel_err12),
        .result_q  (result12_q),
        .sel_err_q (sel_err12_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        data   = v.data;
        select = v.sel;
        exp_q16.push_back(v);
    endtask

    task automatic applyStimulus12(input vec_t v);
        data12   = v.data[11:0];
        select12 = v.sel;
        exp_q12.push_back(v);
    endtask

    initial begin
        vec_t v;

        // A5C3 = 1010_0101_1100_0011, bits listed LSB first.
        vecs16[0]  = '{16'hA5C3, 4'd0,  1'b1, 1'b0};
        vecs16[1]  = '{16'hA5C3, 4'd1,  1'b1, 1'b0};
        vecs16[2]  = '{16'hA5C3, 4'd2,  1'b0, 1'b0};
        vecs16[3]  = '{16'hA5C3, 4'd3,  1'b0, 1'b0};
        vecs16[4]  = '{16'hA5C3, 4'd4,  1'b0, 1'b0};
        vecs16[5]  = '{16'hA5C3, 4'd5,  1'b0, 1'b0};
        vecs16[6]  = '{16'hA5C3, 4'd6,  1'b1, 1'b0};
        vecs16[7]  = '{16'hA5C3, 4'd7,  1'b1, 1'b0};
        vecs16[8]  = '{16'hA5C3, 4'd8,  1'b1, 1'b0};
        vecs16[9]  = '{16'hA5C3, 4'd9,  1'b0, 1'b0};
        vecs16[10] = '{16'hA5C3, 4'd10, 1'b1, 1'b0};
        vecs16[11] = '{16'hA5C3, 4'd11, 1'b0, 1'b0};
        vecs16[12] = '{16'hA5C3, 4'd12, 1'b0, 1'b0};
        vecs16[13] = '{16'hA5C3, 4'd13, 1'b1, 1'b0};
        vecs16[14] = '{16'hA5C3, 4'd14, 1'b0, 1'b0};
        vecs16[15] = '{16'hA5C3, 4'd15, 1'b1, 1'b0};
        vecs16[16] = '{16'h8001, 4'd15, 1'b1, 1'b0};
        vecs16[17] = '{16'h8001, 4'd1,  1'b0, 1'b0};
        vecs16[18] = '{16'h8001, 4'd0,  1'b1, 1'b0};
        vecs16[19] = '{16'hFFFF, 4'd7,  1'b1, 1'b0};
        vecs16[20] = '{16'h0000, 4'd7,  1'b0, 1'b0};
        vecs16[21] = '{16'h7FFF, 4'd15, 1'b0, 1'b0};
        vecs16[22] = '{16'h0001, 4'd15, 1'b0, 1'b0};

        vecs12[0]  = '{16'h0FFF, 4'd13, 1'b0, 1'b1};
        vecs12[1]  = '{16'h0FFF, 4'd11, 1'b1, 1'b0};
        vecs12[2]  = '{16'h0FFF, 4'd12, 1'b0, 1'b1};
        vecs12[3]  = '{16'h0FFF, 4'd15, 1'b0, 1'b1};
        vecs12[4]  = '{16'h0FFF, 4'd0,  1'b1, 1'b0};
        vecs12[5]  = '{16'h0800, 4'd11, 1'b1, 1'b0};

        rst_n    = 1'b0;
        data     = 16'h0020;
        select   = 4'd5;
        data12   = 12'h000;
        select12 = 4'd0;

        // Reset state, and combinational path alive during reset.
        #2;
        checkOutput("reset_result_q", result_q, 1'b0);
        checkOutput("reset_sel_err_q", sel_err_q, 1'b0);
        checkOutput("reset_comb_result", result, 1'b1);
        @(posedge clk); #1;
        checkOutput("reset_hold_result_q", result_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data toggles at a fixed select with no clock edge in between.
        @(negedge clk);
        select = 4'd5;
        data   = 16'h0020;
        #1 checkOutput("data_toggle_hi", result, 1'b1);
        #1 data = 16'h0000;
        #1 checkOutput("data_toggle_lo", result, 1'b0);

        $display("[TB] running 16-bit vector table");
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            applyStimulus(vecs16[i]);
            #1;
            checkOutput($sformatf("comb_result[%0d]", i), result, vecs16[i].exp_result);
            checkOutput($sformatf("comb_sel_err[%0d]", i), sel_err, vecs16[i].exp_err);
            @(posedge clk); #1;
            v = exp_q16.pop_front();
            checkOutput($sformatf("result_q[%0d]", i), result_q, v.exp_result);
            checkOutput($sformatf("sel_err_q[%0d]", i), sel_err_q, v.exp_err);
        end

        $display("[TB] running 12-bit out-of-range table");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus12(vecs12[i]);
            #1;
            checkOutput($sformatf("w12_result[%0d]", i), result12, vecs12[i].exp_result);
            checkOutput($sformatf("w12_sel_err[%0d]", i), sel_err12, vecs12[i].exp_err);
            @(posedge clk); #1;
            v = exp_q12.pop_front();
            checkOutput($sformatf("w12_result_q[%0d]", i), result12_q, v.exp_result);
            checkOutput($sformatf("w12_sel_err_q[%0d]", i), sel_err12_q, v.exp_err);
        end

        // Mid-operation asynchronous reset between clock edges.
        $display("[TB] running async reset sequence");
        @(negedge clk);
        data     = 16'h8001;
        select   = 4'd0;
        data12   = 12'hFFF;
        select12 = 4'd13;
        @(posedge clk); #1;
        checkOutput("pre_reset_result_q", result_q, 1'b1);
        checkOutput("pre_reset_w12_sel_err_q", sel_err12_q, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_result_q", result_q, 1'b0);
        checkOutput("async_reset_sel_err_q", sel_err_q, 1'b0);
        checkOutput("async_reset_w12_sel_err_q", sel_err12_q, 1'b0);
        checkOutput("reset_comb_tracks_a", result, 1'b1);
        select = 4'd1;
        #1 checkOutput("reset_comb_tracks_b", result, 1'b0);
        checkOutput("reset_w12_comb_err", sel_err12, 1'b1);
        select = 4'd15;
        @(posedge clk); #1;
        checkOutput("reset_held_result_q", result_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_result_q", result_q, 1'b1);
        checkOutput("post_reset_w12_sel_err_q", sel_err12_q, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter: width, default 16, number of data inputs (bits of data); legal range 2..1024.
REQ-002 Parameter: channels, default 4, width of the select bus; must satisfy 2**channels >= width, otherwise elaboration SHALL fail with an error.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for registered outputs.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data  input  width  data bits; bit i is the channel i input.
REQ-007 select  input  channels  index of the data bit to route.
REQ-008 result  output  1  combinational selected bit.
REQ-009 sel_err  output  1  combinational flag; high when select >= width.
REQ-010 result_q  output  1  registered copy of result.
REQ-011 sel_err_q  output  1  registered copy of sel_err.

Function
REQ-012 result SHALL equal data[select] whenever select < width, with zero clock latency (pure combinational path from data and select).
REQ-013 result SHALL be 0 and sel_err SHALL be 1 when select >= width; sel_err SHALL be 0 otherwise.
REQ-014 result and sel_err SHALL settle within the same clock phase in which select or data changes; no clock edge is required.
REQ-015 result_q and sel_err_q SHALL capture result and sel_err on every rising clk edge when rst_n is high (one-cycle latency).
REQ-016 Simultaneous change of data and select SHALL yield the bit of the new data at the new index; no glitch guarantee is required on the combinational outputs.
REQ-017 Select index arithmetic SHALL be unsigned; no wrap-around modulo width is permitted (out-of-range handling per REQ-013 only).
REQ-018 Selection SHALL be built as a balanced binary tree of 2:1 stages, channels levels deep, with data padded with zeros up to 2**channels inputs.
REQ-019 No X SHALL propagate to result when select is fully known; an X on any select bit MAY produce X.

Reset
REQ-020 While rst_n is low, result_q = 0 and sel_err_q = 0, asserted asynchronously without waiting for clk.
REQ-021 Reset SHALL NOT affect result or sel_err, which keep following data and select.
REQ-022 On rst_n release, the first rising clk edge SHALL load the registered outputs normally; deassertion is synchronous to clk by the integrating system.
REQ-023 Reset asserted mid-operation SHALL clear result_q and sel_err_q immediately; the value captured before reset is lost.

Structure
REQ-024 A shared package mux_pkg SHALL hold the default parameter values (MUX_WIDTH_DEF = 16, MUX_CHANNELS_DEF = 4) and a function computing the minimum select width for a given width.
REQ-025 One sub-module, mux2_cell (a, b, s -> y), SHALL be instantiated per tree node via generate loops; mux SHALL contain the tree, range check and output registers.

Verification
REQ-026 Sweep: data = 16'hA5C3, select stepped 0..15 on each rising edge -> at each following falling edge, result == data[select] (e.g. select 0 -> 1, select 2 -> 0, select 15 -> 1); sel_err = 0 throughout.
REQ-027 Registered path: data = 16'h8001, select = 15 then 1 then 0 on consecutive edges -> result_q is 1, 0, 1, each one cycle after the corresponding select.
REQ-028 Out-of-range: width = 12, channels = 4, data = 12'hFFF, select = 13 -> result = 0, sel_err = 1; select = 11 -> result = 1, sel_err = 0.
REQ-029 Async reset: with result_q = 1, drive rst_n low between clock edges -> result_q and sel_err_q become 0 before the next edge; result keeps tracking data[select].
REQ-030 Data change at fixed select: select = 5, data toggles 16'h0020 -> 16'h0000 -> result goes 1 -> 0 with no clock edge in between.
REQ-031 Elaboration check: width = 16, channels = 3 -> build SHALL fail with a parameter error.
